nth_fifo_wc: RTL

- Instrumented elastic FIFO between a page's stream port and the overlay NoC leaf.
- Successor to the fixed-width single-depth queue: adds a parametrised depth and integer-ratio width conversion (pack or unpack).
- Adds saturating performance counters, including a new write counter.
- Feeds the same full/empty/read counters and stall_condition into the page monitor.

---
 rtl/nth_fifo_pkg.sv | 28 ++
 rtl/nth_fifo_wc_ram.sv | 52 +++++
 rtl/nth_fifo_wc.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/nth_fifo_pkg.sv
// nth_fifo_pkg: shared mode encodings and helpers for nth_fifo_wc.
// Width ratio, conversion mode and saturating counter increment.
package nth_fifo_pkg;

    localparam logic [1:0] MODE_PASS   = 2'd0;
    localparam logic [1:0] MODE_PACK   = 2'd1;
    localparam logic [1:0] MODE_UNPACK = 2'd2;

    localparam int CNT_MAX_BITS = 64;

    function automatic int calc_ratio(input int in_w, input int out_w);
        return (in_w > out_w) ? (in_w / out_w) : (out_w / in_w);
    endfunction

    function automatic logic [1:0] calc_mode(input int in_w, input int out_w);
        if (out_w > in_w) return MODE_PACK;
        if (in_w > out_w) return MODE_UNPACK;
        return MODE_PASS;
    endfunction

    function automatic logic [CNT_MAX_BITS-1:0] sat_inc(
        input logic [CNT_MAX_BITS-1:0] v,
        input logic [CNT_MAX_BITS-1:0] max
    );
        return (v == max) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/nth_fifo_wc_ram.sv
// nth_fifo_wc_ram: SW x 2^ASIZE distributed storage with pointer logic.
// Pointers carry one extra wrap bit to tell full from empty.
module nth_fifo_wc_ram
    import nth_fifo_pkg::*;
#(
    parameter int SW    = 32,
    parameter int ASIZE = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_wr_en,
    input  logic [SW-1:0] i_wr_data,
    input  logic          i_rd_en,
    output logic [SW-1:0] o_rd_data,
    output logic          o_full,
    output logic          o_empty
);

    localparam int DEPTH = 1 << ASIZE;

    logic [SW-1:0]  r_mem [DEPTH];
    logic [ASIZE:0] r_wptr;
    logic [ASIZE:0] r_rptr;
    logic           w_wr;
    logic           w_rd;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[ASIZE] != r_rptr[ASIZE]) &&
                     (r_wptr[ASIZE-1:0] == r_rptr[ASIZE-1:0]);

    assign w_wr = i_wr_en & ~o_full;
    assign w_rd = i_rd_en & ~o_empty;

    assign o_rd_data = r_mem[r_rptr[ASIZE-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr[ASIZE-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + (ASIZE+1)'(1);
            if (w_rd) r_rptr <= r_rptr + (ASIZE+1)'(1);
        end
    end

endmodule

// File: rtl/nth_fifo_wc.sv
// nth_fifo_wc: instrumented elastic FIFO with integer-ratio width conversion.
// Define NTH_FIFO_WC_FLUSH_EN to add a flush input that clears data state.
module nth_fifo_wc
    import nth_fifo_pkg::*;
#(
    parameter int PAYLOAD_BITS = 32,
    parameter int IN_WIDTH     = 32,
    parameter int OUT_WIDTH    = 32,
    parameter int ASIZE        = 5,
    parameter int INPUT_PORT   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [IN_WIDTH-1:0]     d_a,
    input  logic                    vld_a,
    output logic                    rdy_a,
    output logic [OUT_WIDTH-1:0]    d_b,
    output logic                    vld_b,
    input  logic                    rdy_b,
`ifdef NTH_FIFO_WC_FLUSH_EN
    input  logic                    flush,
`endif
    input  logic                    is_done_mode_user,
    output logic [PAYLOAD_BITS-1:0] full_cnt,
    output logic [PAYLOAD_BITS-1:0] empty_cnt,
    output logic [PAYLOAD_BITS-1:0] read_cnt,
    output logic [PAYLOAD_BITS-1:0] write_cnt,
    output logic                    stall_condition
);

    localparam int SW    = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
    localparam int R     = calc_ratio(IN_WIDTH, OUT_WIDTH);
    localparam logic [1:0] MODE = calc_mode(IN_WIDTH, OUT_WIDTH);
    localparam int R_IN  = (MODE == MODE_PACK) ? R : 1;
    localparam int R_OUT = (MODE == MODE_UNPACK) ? R : 1;
    localparam int IDXW  = (R > 1) ? $clog2(R) : 1;
    localparam logic [CNT_MAX_BITS-1:0] CNT_MAX =
        CNT_MAX_BITS'({PAYLOAD_BITS{1'b1}});

    if (((IN_WIDTH % OUT_WIDTH) != 0) && ((OUT_WIDTH % IN_WIDTH) != 0)) begin : g_bad_ratio
        $error("nth_fifo_wc: IN_WIDTH and OUT_WIDTH must be integer multiples");
    end
    if (PAYLOAD_BITS > CNT_MAX_BITS) begin : g_bad_cnt
        $error("nth_fifo_wc: PAYLOAD_BITS too wide");
    end

    logic            w_clr;
    logic            w_full;
    logic            w_empty;
    logic            w_in_hs;
    logic            w_in_last;
    logic            w_wr_en;
    logic            w_out_hs;
    logic            w_out_last;
    logic            w_pop;
    logic [SW-1:0]   w_pack_word;
    logic [SW-1:0]   w_rd_word;
    logic [SW-1:0]   r_acc;
    logic [SW-1:0]   r_dout;
    logic [IDXW-1:0] r_pidx;
    logic [IDXW-1:0] r_oidx;
    logic            r_vld;

`ifdef NTH_FIFO_WC_FLUSH_EN
    assign w_clr = reset | flush;
    assign rdy_a = ~w_full & ~flush;
`else
    assign w_clr = reset;
    assign rdy_a = ~w_full;
`endif

    // Pack side: the last beat is merged combinationally into the stored word.
    assign w_in_hs   = vld_a & rdy_a;
    assign w_in_last = (r_pidx == IDXW'(R_IN - 1));
    assign w_wr_en   = w_in_hs & w_in_last;

    always_comb begin
        w_pack_word = r_acc;
        w_pack_word[32'(r_pidx) * IN_WIDTH +: IN_WIDTH] = d_a;
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_acc  <= '0;
            r_pidx <= '0;
        end else if (w_in_hs) begin
            r_acc  <= w_pack_word;
            r_pidx <= w_in_last ? '0 : r_pidx + IDXW'(1);
        end
    end

    nth_fifo_wc_ram #(
        .SW    (SW),
        .ASIZE (ASIZE)
    ) u_ram (
        .clk       (clk),
        .reset     (w_clr),
        .i_wr_en   (w_wr_en),
        .i_wr_data (w_pack_word),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_word),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign w_out_hs   = r_vld & rdy_b;
    assign w_out_last = (r_oidx == IDXW'(R_OUT - 1));
    assign w_pop      = ~w_empty & (~r_vld | (w_out_hs & w_out_last));

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_vld  <= 1'b0;
            r_oidx <= '0;
        end else if (w_pop) begin
            r_vld  <= 1'b1;
            r_dout <= w_rd_word;
            r_oidx <= '0;
        end else if (w_out_hs) begin
            if (w_out_last) r_vld <= 1'b0;
            else            r_oidx <= r_oidx + IDXW'(1);
        end
    end

    assign vld_b = r_vld;
    assign d_b   = r_dout[32'(r_oidx) * OUT_WIDTH +: OUT_WIDTH];

    function automatic logic [PAYLOAD_BITS-1:0] bump(
        input logic [PAYLOAD_BITS-1:0] v
    );
        return PAYLOAD_BITS'(sat_inc(CNT_MAX_BITS'(v), CNT_MAX));
    endfunction

    // Counters keep their value across flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_cnt  <= '0;
            empty_cnt <= '0;
            read_cnt  <= '0;
            write_cnt <= '0;
        end else if (!is_done_mode_user) begin
            if (w_full)   full_cnt  <= bump(full_cnt);
            if (w_empty)  empty_cnt <= bump(empty_cnt);
            if (w_out_hs) read_cnt  <= bump(read_cnt);
            if (w_in_hs)  write_cnt <= bump(write_cnt);
        end
    end

    if (INPUT_PORT != 0) begin : g_stall_in
        assign stall_condition = ~is_done_mode_user & rdy_b & ~r_vld;
    end else begin : g_stall_out
        assign stall_condition = ~is_done_mode_user & vld_a & w_full;
    end

endmodule
